// File: rtl/unum4_unpack_if.sv
// ---------------------------------------------------------------------------
// Module : unum4_unpack_if
// Brief  : Operand-side bus for the unum4 unpack pipeline (word in, fields out).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface unum4_unpack_if #(
    parameter int DATA_W    = 32,
    parameter int MAN_MAX_W = 29,
    parameter int EXP_MAX_W = 16,
    parameter int EXTRA     = 3
);
    logic                         start;
    logic [DATA_W-1:0]            data_in;
    logic                         done;
    logic [EXP_MAX_W-1:0]         exp;
    logic [MAN_MAX_W+EXTRA-1:0]   mant;
    logic                         zero;

    modport master (output start, data_in, input done, exp, mant, zero);
    modport slave  (input start, data_in, output done, exp, mant, zero);
endinterface

`default_nettype wire

// File: rtl/unum4_unpack.sv
// ---------------------------------------------------------------------------
// Module : unum4_unpack
// Brief  : 3-stage pipelined unpack of a unum4 word into exponent/mantissa.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module unum4_unpack #(
    parameter int DATA_W    = 32,
    parameter int MAN_MAX_W = 29,
    parameter int EXP_SZ_W  = 4,
    parameter int EXP_MAX_W = 16,
    parameter int EXTRA     = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    unum4_unpack_if.slave     bus
);
    localparam int c_F    = DATA_W - EXP_SZ_W;
    localparam int c_EF_W = (1 << EXP_SZ_W) - 1;
    localparam int c_MW   = MAN_MAX_W + EXTRA;

    // Stage 1
    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= bus.start;
            s1_data_q <= bus.data_in;
        end
    end

    // Stage 2
    logic [EXP_SZ_W-1:0]  w_es;
    logic [c_F-1:0]       w_body;
    logic [c_F-1:0]       w_frac;
    logic [c_EF_W-1:0]    s2_e_d,   s2_e_q;
    logic [MAN_MAX_W-1:0] s2_m_d,   s2_m_q;
    logic                 s2_sgn_d, s2_sgn_q;
    logic [EXP_SZ_W-1:0]  s2_es_q;
    logic                 s2_vld_q;

    always_comb begin
        w_es   = s1_data_q[EXP_SZ_W-1:0];
        w_body = s1_data_q[DATA_W-1:EXP_SZ_W];
        w_frac = w_body << w_es;
        s2_e_d = c_EF_W'(w_body >> (c_F - int'(w_es)));
        // The exponent sign is always the top bit of the word when es != 0.
        s2_sgn_d = (w_es != '0) & w_body[c_F-1];
        if (w_es == '0) begin
            s2_m_d = {w_body[c_F-1], w_body};
        end else begin
            s2_m_d = {~w_frac[c_F-1], w_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_e_q   <= '0;
            s2_m_q   <= '0;
            s2_sgn_q <= 1'b0;
            s2_es_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_e_q   <= s2_e_d;
            s2_m_q   <= s2_m_d;
            s2_sgn_q <= s2_sgn_d;
            s2_es_q  <= w_es;
        end
    end

    // Stage 3
    logic [EXP_MAX_W-1:0] w_e_ext;
    logic [EXP_MAX_W-1:0] w_mask;
    logic [EXP_MAX_W-1:0] exp_d,  exp_q;
    logic [c_MW-1:0]      mant_d, mant_q;
    logic                 zero_d, zero_q;
    logic                 done_q;

    always_comb begin
        w_e_ext                = '0;
        w_e_ext[c_EF_W-1:0]    = s2_e_q;
        w_mask                 = {EXP_MAX_W{1'b1}} << s2_es_q;
        // Sign-extend, then +1 undoes the one's-complement applied on pack.
        exp_d  = (s2_sgn_q ? (w_e_ext | w_mask) : w_e_ext)
                 + {{(EXP_MAX_W-1){1'b0}}, s2_sgn_q};
        mant_d = {s2_m_q, {EXTRA{1'b0}}};
        zero_d = (s2_es_q == '0) && (s2_m_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            zero_q <= 1'b0;
        end else begin
            done_q <= s2_vld_q;
            if (s2_vld_q) begin
                exp_q  <= exp_d;
                mant_q <= mant_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.done = done_q;
    assign bus.exp  = exp_q;
    assign bus.mant = mant_q;
    assign bus.zero = zero_q;
endmodule

`default_nettype wire

// File: doc/unum4_unpack.md
Name: unum4_unpack

Overview:
- Inverse of the unum4 pack unit: takes one packed unum4 word and recovers the exponent and the mantissa in the internal two's-complement format, with EXTRA guard bits.
- Sits at the load/operand side of the unum4 arithmetic units and feeds add/mul directly.
- Fully pipelined: one word accepted per cycle, fixed latency, start/done handshake.

Parameters:
- DATA_W, 32: packed word width.
- MAN_MAX_W, 29: internal mantissa width, sign bit included.
- EXP_SZ_W, 4: width of the exponent-size field.
- EXP_MAX_W, 16: internal exponent width.
- EXTRA, 3: zero guard bits appended below the mantissa.
- Legal set: DATA_W-EXP_SZ_W = MAN_MAX_W-1, and 2^EXP_SZ_W-1 <= EXP_MAX_W. Other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  data_in valid this cycle
- data_in  in  DATA_W  packed unum4 word
- done  out  1  exp/mant/zero valid this cycle
- exp  out  EXP_MAX_W  two's-complement exponent
- mant  out  MAN_MAX_W+EXTRA  mantissa, low EXTRA bits always 0
- zero  out  1  decoded value is zero

Behaviour:
- Reset: one clock with rst=1 clears every pipeline register and valid bit.
  - done=0, exp=0, mant=0, zero=0 from the following cycle.
  - Tokens in flight are discarded, and done stays 0 until a new start has propagated.
  - rst has priority over start in the same cycle.
- Latency: exactly 3 cycles. start in cycle t gives done=1 with the matching results in cycle t+3. Throughput is 1 per cycle with no stall and no backpressure.
  - Stage 1 registers data_in and start.
  - Stage 2 decodes es, aligns the fields with a variable shift, and registers the raw exponent field and the mantissa.
  - Stage 3 applies exponent sign-extension and correction, computes zero, and registers the outputs.
- Outputs hold their last values while done=0. Only done is qualified.
- Field layout, with es = data_in[EXP_SZ_W-1:0] and F = DATA_W-EXP_SZ_W (28 by default):
  - es = 0 (denormal/zero class):
    - exp = 0.
    - mant[MAN_MAX_W+EXTRA-1:EXTRA] = sign-extension of data_in[DATA_W-1:EXP_SZ_W] by 1 bit.
    - zero = 1 iff data_in[DATA_W-1:EXP_SZ_W] = 0.
  - es in 1..2^EXP_SZ_W-1 (normalized class):
    - Exponent field E = data_in[DATA_W-1 -: es], i.e. es bits taken from the top of the word.
    - Mantissa field M = data_in[DATA_W-1-es : EXP_SZ_W], F-es bits.
    - m[MAN_MAX_W-2 -: F-es] = M, lower m bits = 0.
    - Hidden bit: m[MAN_MAX_W-1] = ~m[MAN_MAX_W-2].
    - mant = {m, EXTRA zeros}. zero = 0.
    - exp = sign-extend(E) to EXP_MAX_W. If E[es-1]=1, add 1 to undo the pack's one's-complement step. An all-ones E therefore gives exp = 0.
- es = 2^EXP_SZ_W-1 is decoded by the normal rule and is not treated as special.
- No illegal inputs: every data_in value produces a defined output.

Test Plan:
- data_in=0x00000000, start=1 at t → at t+3: done=1, exp=0x0000, mant=0x00000000, zero=1; done=0 at t+4.
- data_in=0x80000000 (es=0, negative denormal) → exp=0x0000, mant=0xC0000000, zero=0.
- data_in=0x40000002 (es=2, E=01, M=0) → exp=0x0001, mant=0x80000000, zero=0.
- data_in=0xD0000003 (es=3, E=110, M top bit 1) → exp=0xFFFF, mant=0x40000000, zero=0.
- Streaming: the three words above on consecutive cycles t, t+1, t+2 → done high for t+3..t+5, with results in input order and no bubbles.
- Reset mid-flight: start at t, rst=1 at t+1 → done=0 and all outputs 0 through t+5. A new start at t+3 yields done at t+6 with the correct result.
